rv32_exec_ctrl: RTL and testbench
=================================

// Module: rv32_exec_ctrl
// PURPOSE
// RV32I execute/control core for the multi-cycle CPU: a control FSM sequences fetch/execute/mem/writeback
// and decodes opcode/f3/f7 into datapath selects. It also contains a 32-bit ALU and a branch comparison unit.
// The CPU top level supplies the decoder fields and register/PC/imm operands, and owns the muxes, PC and memory unit.
// PARAMETERS
// none (XLEN fixed at 32)
// PORTS
// clk            in   1   clock, rising edge
// rst            in   1   asynchronous, active-low reset
// stall          in   1   1 = an instruction or data bus transaction is still pending
// opcode         in   7   ir[6:0]
// f3             in   3   ir[14:12]
// f7             in   7   ir[31:25]
// alu_a/alu_b    in   32  ALU operands (already muxed by the top level)
// cmp_a/cmp_b    in   32  comparison operands (rs1, rs2)
// alu_out        out  32  ALU result
// cmp_result     out  1   branch condition is true
// alu_mode       out  4   decoded ALU operation
// alu_in_a       out  1   operand A select: 0 = rs1, 1 = PC
// alu_in_b       out  1   operand B select: 0 = rs2, 1 = imm
// dest_reg_from  out  2   rd source: 0 = NONE, 1 = ALU, 2 = BUS, 3 = next_pc
// pc_src         out  1   0 = PC counter (step), 1 = load PC from alu_out
// en_comp_unit   out  1   branch instruction; PC step = imm when cmp_result=1
// dbus_re/dbus_we out 1   data bus read / write request
// load_ir, en_iaddr, en_pc_counter, write_back_stage  out  1  stage strobes
// BEHAVIOUR
// - FSM states: FETCH -> EXEC -> (MEM) -> WB -> FETCH.
// - rst low (at any time, including mid-instruction): state = FETCH immediately.
// - Values while rst is low: en_iaddr = 1, load_ir = 1, and every other output is 0.
// - FETCH: en_iaddr = 1, load_ir = 1; all decoded outputs are 0/NONE. Leave FETCH when stall = 0.
// - EXEC: lasts exactly 1 cycle. Go to MEM for load/store opcodes, otherwise to WB.
// - MEM: hold while stall = 1, then go to WB.
// - WB: write_back_stage = 1, en_pc_counter = 1. Hold while stall = 1, then go to FETCH.
// - In EXEC/MEM/WB, the decoded outputs follow opcode/f3/f7 combinationally:
//   LUI 0110111: b = imm, mode PASS_B, dest ALU
//   AUIPC 0010111: a = PC, b = imm, ADD, dest ALU
//   JAL 1101111: a = PC, b = imm, ADD, pc_src = 1, dest PC
//   JALR 1100111: a = rs1, b = imm, ADD, pc_src = 1, dest PC
//   BRANCH 1100011: en_comp_unit = 1, dest NONE
//   LOAD 0000011: rs1 + imm, dbus_re = 1, dest BUS
//   STORE 0100011: rs1 + imm, dbus_we = 1, dest NONE
//   OP-IMM 0010011: b = imm, mode = {f3==101 ? f7[5] : 0, f3}, dest ALU
//   OP 0110011: b = rs2, mode = {f7[5], f3}, dest ALU
//   any other opcode: NOP (all outputs 0 / NONE)
// - ALU (combinational, results mod 2^32) mode encodings:
//   0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR,
//   0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1111 PASS_B.
//   Shift amount = b[4:0]. SLT/SLTU return 0 or 1. Unlisted codes return 0.
// - Comparison (combinational), op = f3:
//   000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 LTU, 111 GEU; 010/011 give 0.
// TESTING
// - Reset in WB with stall = 0 -> next state FETCH, en_iaddr = 1, write_back_stage = 0.
// - ADDI (0010011, f3 = 000), stall = 0 -> FETCH, EXEC, WB, FETCH; in WB: b = imm, dest = 1, mode = 0000.
// - LW with stall held high 3 cycles in MEM -> dbus_re = 1 throughout, WB only after stall falls.
// - ALU: SUB 5 - 7 = 0xFFFFFFFE; SRA 0x80000000 >> 4 = 0xF8000000; SLTU 1 < 0xFFFFFFFF = 1; SLT -1 < 1 = 1.
// - BLT (f3 = 100): a = 0xFFFFFFFF, b = 1 -> cmp_result = 1; BLTU with the same operands -> 0; en_comp_unit = 1.
// - JAL -> a = PC, pc_src = 1, dest = 3; SUB with f7 = 0100000 on OP-IMM f3 = 000 -> mode = ADD.

Source files
------------

// File: rtl/rv32_exec_ctrl.sv
// RV32I execute/control core: stage-sequencing FSM, instruction decode into datapath
// selects, 32-bit ALU and branch comparison unit.
module rv32_exec_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [6:0]  opcode,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [31:0] cmp_a,
    input  logic [31:0] cmp_b,
    output logic [31:0] alu_out,
    output logic        cmp_result,
    output logic [3:0]  alu_mode,
    output logic        alu_in_a,
    output logic        alu_in_b,
    output logic [1:0]  dest_reg_from,
    output logic        pc_src,
    output logic        en_comp_unit,
    output logic        dbus_re,
    output logic        dbus_we,
    output logic        load_ir,
    output logic        en_iaddr,
    output logic        en_pc_counter,
    output logic        write_back_stage
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] M_ADD  = 4'b0000;
    localparam logic [3:0] M_SUB  = 4'b1000;
    localparam logic [3:0] M_SLL  = 4'b0001;
    localparam logic [3:0] M_SLT  = 4'b0010;
    localparam logic [3:0] M_SLTU = 4'b0011;
    localparam logic [3:0] M_XOR  = 4'b0100;
    localparam logic [3:0] M_SRL  = 4'b0101;
    localparam logic [3:0] M_SRA  = 4'b1101;
    localparam logic [3:0] M_OR   = 4'b0110;
    localparam logic [3:0] M_AND  = 4'b0111;
    localparam logic [3:0] M_PASS = 4'b1111;

    localparam logic [1:0] D_NONE = 2'd0;
    localparam logic [1:0] D_ALU  = 2'd1;
    localparam logic [1:0] D_BUS  = 2'd2;
    localparam logic [1:0] D_PC   = 2'd3;

    state_t state, state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH: if (!stall) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = (opcode == OPC_LOAD || opcode == OPC_STORE) ? S_MEM : S_WB;
            S_MEM:   if (!stall) state_nxt = S_WB;
            S_WB:    if (!stall) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Stage strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_FETCH;
            en_iaddr         <= 1'b1;
            load_ir          <= 1'b1;
            write_back_stage <= 1'b0;
            en_pc_counter    <= 1'b0;
        end else begin
            state            <= state_nxt;
            en_iaddr         <= (state_nxt == S_FETCH);
            load_ir          <= (state_nxt == S_FETCH);
            write_back_stage <= (state_nxt == S_WB);
            en_pc_counter    <= (state_nxt == S_WB);
        end
    end

    always_comb begin
        alu_mode      = M_ADD;
        alu_in_a      = 1'b0;
        alu_in_b      = 1'b0;
        dest_reg_from = D_NONE;
        pc_src        = 1'b0;
        en_comp_unit  = 1'b0;
        dbus_re       = 1'b0;
        dbus_we       = 1'b0;
        if (state != S_FETCH) begin
            unique case (opcode)
                OPC_LUI: begin
                    alu_in_b      = 1'b1;
                    alu_mode      = M_PASS;
                    dest_reg_from = D_ALU;
                end
                OPC_AUIPC: begin
                    alu_in_a      = 1'b1;
                    alu_in_b      = 1'b1;
                    dest_reg_from = D_ALU;
                end
                OPC_JAL: begin
                    alu_in_a      = 1'b1;
                    alu_in_b      = 1'b1;
                    pc_src        = 1'b1;
                    dest_reg_from = D_PC;
                end
                OPC_JALR: begin
                    alu_in_b      = 1'b1;
                    pc_src        = 1'b1;
                    dest_reg_from = D_PC;
                end
                OPC_BRANCH: en_comp_unit = 1'b1;
                OPC_LOAD: begin
                    alu_in_b      = 1'b1;
                    dbus_re       = 1'b1;
                    dest_reg_from = D_BUS;
                end
                OPC_STORE: begin
                    alu_in_b = 1'b1;
                    dbus_we  = 1'b1;
                end
                OPC_OPIMM: begin
                    // f7[5] only selects SRA among immediate ops; elsewhere it is immediate data.
                    alu_in_b      = 1'b1;
                    alu_mode      = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
                    dest_reg_from = D_ALU;
                end
                OPC_OP: begin
                    alu_mode      = {f7[5], f3};
                    dest_reg_from = D_ALU;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_out = '0;
        unique case (alu_mode)
            M_ADD:  alu_out = alu_a + alu_b;
            M_SUB:  alu_out = alu_a - alu_b;
            M_SLL:  alu_out = alu_a << alu_b[4:0];
            M_SLT:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            M_SLTU: alu_out = {31'b0, alu_a < alu_b};
            M_XOR:  alu_out = alu_a ^ alu_b;
            M_SRL:  alu_out = alu_a >> alu_b[4:0];
            M_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            M_OR:   alu_out = alu_a | alu_b;
            M_AND:  alu_out = alu_a & alu_b;
            M_PASS: alu_out = alu_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        cmp_result = 1'b0;
        unique case (f3)
            3'b000:  cmp_result = (cmp_a == cmp_b);
            3'b001:  cmp_result = (cmp_a != cmp_b);
            3'b100:  cmp_result = ($signed(cmp_a) < $signed(cmp_b));
            3'b101:  cmp_result = ($signed(cmp_a) >= $signed(cmp_b));
            3'b110:  cmp_result = (cmp_a < cmp_b);
            3'b111:  cmp_result = (cmp_a >= cmp_b);
            default: cmp_result = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Directed bench for rv32_exec_ctrl: FSM sequencing, decode, ALU and branch compare.
module tb_rv32_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] alu_a, alu_b, cmp_a, cmp_b;
    logic [31:0] alu_out;
    logic        cmp_result;
    logic [3:0]  alu_mode;
    logic        alu_in_a, alu_in_b;
    logic [1:0]  dest_reg_from;
    logic        pc_src, en_comp_unit, dbus_re, dbus_we;
    logic        load_ir, en_iaddr, en_pc_counter, write_back_stage;

    int unsigned checks = 0;
    int unsigned errors = 0;

    rv32_exec_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .opcode(opcode), .f3(f3), .f7(f7),
        .alu_a(alu_a), .alu_b(alu_b), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .alu_out(alu_out), .cmp_result(cmp_result), .alu_mode(alu_mode),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .dest_reg_from(dest_reg_from),
        .pc_src(pc_src), .en_comp_unit(en_comp_unit),
        .dbus_re(dbus_re), .dbus_we(dbus_we),
        .load_ir(load_ir), .en_iaddr(en_iaddr),
        .en_pc_counter(en_pc_counter), .write_back_stage(write_back_stage)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0;
        opcode = 7'b0010011; f3 = 3'b000; f7 = 7'b0;
        alu_a = '0; alu_b = '0; cmp_a = '0; cmp_b = '0;
        #15;
        chk("rst_en_iaddr", 32'(en_iaddr), 32'd1);
        chk("rst_load_ir",  32'(load_ir), 32'd1);
        chk("rst_wb",       32'(write_back_stage), 32'd0);
        chk("rst_en_pc",    32'(en_pc_counter), 32'd0);
        chk("rst_dest",     32'(dest_reg_from), 32'd0);
        chk("rst_in_b",     32'(alu_in_b), 32'd0);

        // ADDI: FETCH -> EXEC -> WB -> FETCH
        rst = 1'b1;
        tick();
        chk("addi_exec_iaddr", 32'(en_iaddr), 32'd0);
        chk("addi_exec_ir",    32'(load_ir), 32'd0);
        chk("addi_exec_wb",    32'(write_back_stage), 32'd0);
        chk("addi_exec_dest",  32'(dest_reg_from), 32'd1);
        tick();
        chk("addi_wb_wb",    32'(write_back_stage), 32'd1);
        chk("addi_wb_pc",    32'(en_pc_counter), 32'd1);
        chk("addi_wb_in_b",  32'(alu_in_b), 32'd1);
        chk("addi_wb_dest",  32'(dest_reg_from), 32'd1);
        chk("addi_wb_mode",  32'(alu_mode), 32'h0);
        tick();
        chk("addi_fetch_iaddr", 32'(en_iaddr), 32'd1);
        chk("addi_fetch_ir",    32'(load_ir), 32'd1);
        chk("addi_fetch_wb",    32'(write_back_stage), 32'd0);
        chk("addi_fetch_dest",  32'(dest_reg_from), 32'd0);

        // LW with stall held in MEM
        opcode = 7'b0000011; f3 = 3'b010;
        #1;
        chk("lw_fetch_re", 32'(dbus_re), 32'd0);
        tick();
        chk("lw_exec_re",   32'(dbus_re), 32'd1);
        chk("lw_exec_in_b", 32'(alu_in_b), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_mem_re",   32'(dbus_re), 32'd1);
            chk("lw_mem_wb",   32'(write_back_stage), 32'd0);
            chk("lw_mem_dest", 32'(dest_reg_from), 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("lw_wb_wb", 32'(write_back_stage), 32'd1);
        chk("lw_wb_re", 32'(dbus_re), 32'd1);
        tick();
        chk("lw_fetch2_wb", 32'(write_back_stage), 32'd0);
        chk("lw_fetch2_re", 32'(dbus_re), 32'd0);

        // OP into WB, hold there with stall for ALU / compare vectors
        opcode = 7'b0110011; f3 = 3'b000; f7 = 7'b0;
        tick();
        tick();
        chk("op_wb_wb", 32'(write_back_stage), 32'd1);
        stall = 1'b1;
        f7 = 7'b0100000; alu_a = 32'd5; alu_b = 32'd7;
        #1;
        chk("sub_mode", 32'(alu_mode), 32'h8);
        chk("sub_out",  alu_out, 32'hFFFF_FFFE);
        f3 = 3'b101; alu_a = 32'h8000_0000; alu_b = 32'd4;
        #1;
        chk("sra_mode", 32'(alu_mode), 32'hD);
        chk("sra_out",  alu_out, 32'hF800_0000);
        f7 = 7'b0; f3 = 3'b011; alu_a = 32'd1; alu_b = 32'hFFFF_FFFF;
        #1;
        chk("sltu_out", alu_out, 32'd1);
        f3 = 3'b010; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
        #1;
        chk("slt_out", alu_out, 32'd1);
        tick();
        chk("wb_hold_wb",   32'(write_back_stage), 32'd1);
        chk("wb_hold_ir",   32'(load_ir), 32'd0);

        opcode = 7'b0010011; f3 = 3'b000; f7 = 7'b0100000; alu_a = 32'd5; alu_b = 32'd7;
        #1;
        chk("addi_f7_mode", 32'(alu_mode), 32'h0);
        chk("addi_f7_out",  alu_out, 32'd12);
        opcode = 7'b1100011; f3 = 3'b100; cmp_a = 32'hFFFF_FFFF; cmp_b = 32'd1;
        #1;
        chk("blt_cmp",  32'(cmp_result), 32'd1);
        chk("blt_en",   32'(en_comp_unit), 32'd1);
        chk("blt_dest", 32'(dest_reg_from), 32'd0);
        f3 = 3'b110;
        #1;
        chk("bltu_cmp", 32'(cmp_result), 32'd0);
        opcode = 7'b0000000;
        #1;
        chk("nop_dest", 32'(dest_reg_from), 32'd0);
        chk("nop_en",   32'(en_comp_unit), 32'd0);
        chk("nop_b",    32'(alu_in_b), 32'd0);
        opcode = 7'b1101111;
        #1;
        chk("jal_in_a", 32'(alu_in_a), 32'd1);
        chk("jal_pc",   32'(pc_src), 32'd1);
        chk("jal_dest", 32'(dest_reg_from), 32'd3);
        chk("jal_mode", 32'(alu_mode), 32'h0);

        // Asynchronous reset while in WB
        stall = 1'b0; rst = 1'b0;
        #1;
        chk("rstwb_iaddr", 32'(en_iaddr), 32'd1);
        chk("rstwb_ir",    32'(load_ir), 32'd1);
        chk("rstwb_wb",    32'(write_back_stage), 32'd0);
        chk("rstwb_pc",    32'(en_pc_counter), 32'd0);
        chk("rstwb_psrc",  32'(pc_src), 32'd0);
        chk("rstwb_dest",  32'(dest_reg_from), 32'd0);
        tick();
        chk("rsthold_iaddr", 32'(en_iaddr), 32'd1);
        rst = 1'b1;
        tick();
        chk("post_rst_exec_dest", 32'(dest_reg_from), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
